// File: rtl/signature_checker_if.sv
// Bus between the upstream signature accumulator and the signature checker.
// The master drives the signature stream and golden value; the slave returns the verdict.
`timescale 1ns/1ps
interface signature_checker_if;
   logic [15:0] sig_in;
   logic        sig_done;
   logic [15:0] expected_sig;
   logic [15:0] captured_sig;
   logic [8:0]  cycle_count;
   logic        done;
   logic        pass;
   logic        fail;
   logic        timeout;
   logic        unstable;
   logic [15:0] mismatch_bits;

   modport master (
      output sig_in, sig_done, expected_sig,
      input  captured_sig, cycle_count, done, pass, fail, timeout, unstable, mismatch_bits
   );

   modport slave (
      input  sig_in, sig_done, expected_sig,
      output captured_sig, cycle_count, done, pass, fail, timeout, unstable, mismatch_bits
   );
endinterface

// File: rtl/signature_checker.sv
// Waits for the upstream accumulator to finish, captures its signature, confirms it holds
// steady for STABLE_CYCLES edges and then compares it against the golden value.
`timescale 1ns/1ps
module signature_checker #(
   parameter int unsigned TIMEOUT       = 300,
   parameter int unsigned STABLE_CYCLES = 2
) (
   input  logic              clk,
   input  logic              clear,
   signature_checker_if.slave bus
);
   localparam int unsigned     HOLD_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STABLE_CYCLES - 1);
   localparam logic [8:0]      CYC_LAST  = 9'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_HOLD = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [15:0]       captured_q, captured_d;
   logic [8:0]        cycle_cnt_q, cycle_cnt_d;
   logic [15:0]       mismatch_q, mismatch_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              fail_q, fail_d;
   logic              timeout_q, timeout_d;
   logic              unstable_q, unstable_d;

   // NOTE: every next-state signal takes its held value first, so no path through the case infers a latch.
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      captured_d  = captured_q;
      cycle_cnt_d = cycle_cnt_q;
      mismatch_d  = mismatch_q;
      done_d      = done_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
      timeout_d   = timeout_q;
      unstable_d  = unstable_q;

      unique case (state_q)
         S_RUN: begin
            // Capture wins over a timeout landing on the same edge.
            if (bus.sig_done) begin
               captured_d = bus.sig_in;
               hold_cnt_d = '0;
               state_d    = S_HOLD;
            end else if (cycle_cnt_q == CYC_LAST) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               fail_d    = 1'b1;
               timeout_d = 1'b1;
            end else begin
               cycle_cnt_d = cycle_cnt_q + 9'd1;
            end
         end

         S_HOLD: begin
            // sig_done is deliberately not looked at here; only signature stability matters.
            if (bus.sig_in != captured_q) begin
               state_d    = S_DONE;
               done_d     = 1'b1;
               fail_d     = 1'b1;
               unstable_d = 1'b1;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d    = S_DONE;
               done_d     = 1'b1;
               pass_d     = (captured_q == bus.expected_sig);
               fail_d     = (captured_q != bus.expected_sig);
               mismatch_d = captured_q ^ bus.expected_sig;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end

         S_DONE: begin
            state_d = S_DONE;
         end

         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   // NOTE: clear is synchronous; there is no asynchronous path into these flops.
   always_ff @(posedge clk) begin
      if (clear) begin
         state_q     <= S_RUN;
         hold_cnt_q  <= '0;
         captured_q  <= '0;
         cycle_cnt_q <= '0;
         mismatch_q  <= '0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         timeout_q   <= 1'b0;
         unstable_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         captured_q  <= captured_d;
         cycle_cnt_q <= cycle_cnt_d;
         mismatch_q  <= mismatch_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         timeout_q   <= timeout_d;
         unstable_q  <= unstable_d;
      end
   end

   assign bus.captured_sig  = captured_q;
   assign bus.cycle_count   = cycle_cnt_q;
   assign bus.mismatch_bits = mismatch_q;
   assign bus.done          = done_q;
   assign bus.pass          = pass_q;
   assign bus.fail          = fail_q;
   assign bus.timeout       = timeout_q;
   assign bus.unstable      = unstable_q;
endmodule

// File: tb/tb_signature_checker.sv
// Scoreboard bench for signature_checker: each scenario pushes its predicted verdict,
// which is popped and compared once the checker raises done.
`timescale 1ns/1ps
module tb_signature_checker;
   localparam int TIMEOUT = 300;
   localparam int STABLE  = 2;

   typedef struct {
      logic [15:0] cap;
      logic [8:0]  cnt;
      logic        pass;
      logic        fail;
      logic        tmo;
      logic        unst;
      logic [15:0] mism;
      int          lat;
   } exp_t;

   logic clk   = 1'b0;
   logic clear = 1'b0;
   int   total = 0;
   int   bad   = 0;
   exp_t sb_q[$];

   always #500 clk = ~clk;

   signature_checker_if bus ();

   signature_checker #(
      .TIMEOUT      (TIMEOUT),
      .STABLE_CYCLES(STABLE)
   ) dut (
      .clk  (clk),
      .clear(clear),
      .bus  (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_done"}, 32'(bus.done), 32'd0);
      check({tag, "_pass"}, 32'(bus.pass), 32'd0);
      check({tag, "_fail"}, 32'(bus.fail), 32'd0);
      check({tag, "_tmo"},  32'(bus.timeout), 32'd0);
      check({tag, "_unst"}, 32'(bus.unstable), 32'd0);
      check({tag, "_cap"},  32'(bus.captured_sig), 32'd0);
      check({tag, "_mism"}, 32'(bus.mismatch_bits), 32'd0);
      check({tag, "_cnt"},  32'(bus.cycle_count), 32'd0);
   endtask

   // Clear spans n rising edges; returns 1ns after the last of them.
   task automatic do_clear(input int n);
      @(posedge clk);
      #1 clear = 1'b1;
      repeat (n) @(posedge clk);
      #1 clear = 1'b0;
   endtask

   // Runs n_run RUN cycles, captures cap, optionally glitches or pulses clear mid-period.
   task automatic run_capture(input string tag, input int n_run, input logic [15:0] cap,
                              input logic [15:0] exp_sig, input bit glitch, input bit mid_pulse,
                              input bit push);
      exp_t e;
      bus.sig_in       = cap;
      bus.expected_sig = exp_sig;
      bus.sig_done     = 1'b0;
      repeat (n_run) @(posedge clk);
      #1 bus.sig_done = 1'b1;
      @(posedge clk);
      #1 bus.sig_done = 1'b0;
      if (glitch) bus.sig_in = cap ^ 16'h0001;
      check({tag, "_hold_done"}, 32'(bus.done), 32'd0);
      check({tag, "_hold_tmo"},  32'(bus.timeout), 32'd0);
      check({tag, "_hold_cap"},  32'(bus.captured_sig), 32'(cap));
      check({tag, "_hold_cnt"},  32'(bus.cycle_count), 32'(n_run));
      if (push) begin
         e.cap  = cap;
         e.cnt  = 9'(n_run);
         e.tmo  = 1'b0;
         if (glitch) begin
            e.unst = 1'b1; e.pass = 1'b0; e.fail = 1'b1; e.mism = 16'h0; e.lat = 1;
         end else begin
            e.unst = 1'b0; e.pass = (cap == exp_sig); e.fail = (cap != exp_sig);
            e.mism = cap ^ exp_sig; e.lat = STABLE;
         end
         sb_q.push_back(e);
      end
      if (mid_pulse) begin
         #100 clear = 1'b1;
         #500 clear = 1'b0;
      end
   endtask

   // Counts edges from the reference edge until done, then scores against the queue head.
   task automatic collect(input string tag, input int budget);
      int   lat = 0;
      bit   seen = 0;
      exp_t e;
      while (lat < budget && !seen) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus.done) seen = 1;
      end
      check({tag, "_seen"}, 32'(seen), 32'd1);
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         if (seen) check({tag, "_lat"}, 32'(lat), 32'(e.lat));
         check({tag, "_pass"}, 32'(bus.pass), 32'(e.pass));
         check({tag, "_fail"}, 32'(bus.fail), 32'(e.fail));
         check({tag, "_tmo"},  32'(bus.timeout), 32'(e.tmo));
         check({tag, "_unst"}, 32'(bus.unstable), 32'(e.unst));
         check({tag, "_cap"},  32'(bus.captured_sig), 32'(e.cap));
         check({tag, "_cnt"},  32'(bus.cycle_count), 32'(e.cnt));
         check({tag, "_mism"}, 32'(bus.mismatch_bits), 32'(e.mism));
      end
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      bus.sig_in       = 16'h0;
      bus.sig_done     = 1'b0;
      bus.expected_sig = 16'h0;

      // Reset state
      do_clear(1);
      check_idle("reset");

      // Pass case, then DONE must ignore all inputs
      run_capture("pass", 255, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1);
      collect("pass", 10);
      bus.sig_done = 1'b1; bus.sig_in = 16'hFFFF; bus.expected_sig = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("sticky_done", 32'(bus.done), 32'd1);
      check("sticky_pass", 32'(bus.pass), 32'd1);
      check("sticky_cap",  32'(bus.captured_sig), 32'h1234);
      check("sticky_cnt",  32'(bus.cycle_count), 32'd255);
      check("sticky_mism", 32'(bus.mismatch_bits), 32'd0);

      // Mismatch case
      do_clear(1);
      run_capture("mism", 255, 16'h1234, 16'h1235, 1'b0, 1'b0, 1'b1);
      collect("mism", 10);

      // Unstable case
      do_clear(1);
      run_capture("unst", 40, 16'hBEEF, 16'hBEEF, 1'b1, 1'b0, 1'b1);
      collect("unst", 10);

      // Timeout case, latency measured from the clear edge
      do_clear(1);
      bus.sig_done = 1'b0;
      e.cap = 16'h0; e.cnt = 9'(TIMEOUT - 1); e.pass = 1'b0; e.fail = 1'b1;
      e.tmo = 1'b1; e.unst = 1'b0; e.mism = 16'h0; e.lat = TIMEOUT;
      sb_q.push_back(e);
      collect("tmo", TIMEOUT + 50);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("tmo_hold_cnt",  32'(bus.cycle_count), 32'(TIMEOUT - 1));
      check("tmo_hold_done", 32'(bus.done), 32'd1);

      // Capture coinciding with the timeout edge
      do_clear(1);
      run_capture("simul", TIMEOUT - 1, 16'hA5A5, 16'hA5A5, 1'b0, 1'b0, 1'b1);
      collect("simul", 10);

      // Clear pulse that misses every rising edge during HOLD
      do_clear(1);
      run_capture("pulse", 20, 16'h0F0F, 16'h0F0F, 1'b0, 1'b1, 1'b1);
      collect("pulse", 10);

      // Clear spanning an edge during HOLD, then counting restarts
      do_clear(1);
      run_capture("span", 20, 16'hC3C3, 16'hC3C3, 1'b0, 1'b0, 1'b0);
      clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      check_idle("span");
      repeat (5) @(posedge clk);
      #1;
      check("span_restart_cnt",  32'(bus.cycle_count), 32'd5);
      check("span_restart_done", 32'(bus.done), 32'd0);

      // Multi-cycle clear keeps counter at zero
      @(posedge clk);
      #1 clear = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1 check($sformatf("hold_clear_cnt%0d", i), 32'(bus.cycle_count), 32'd0);
      end
      clear = 1'b0;

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
